// File: rtl/vector_alu_pkg.sv
// Shared types and constants for the pipelined vector ALU.
package vector_alu_pkg;

    // Operation codes; the same code applies to every lane of a transaction.
    typedef enum logic [2:0] {
        OP_PASS  = 3'b000,  // A
        OP_ADD   = 3'b001,  // A+B
        OP_SUB   = 3'b010,  // A-B
        OP_CSUB  = 3'b011,  // A if A<B, else A-B
        OP_INT21 = 3'b100,  // (2A+B)/3
        OP_INT12 = 3'b101,  // (A+2B)/3
        OP_RSV6  = 3'b110,  // all lanes 0
        OP_RSV7  = 3'b111   // all lanes 0
    } valu_op_e;

    // Divisor of the weighted-interpolation operations.
    localparam int DIV_CONST = 3;

endpackage

// File: rtl/vector_alu_lane.sv
// One lane of the vector ALU datapath: the combinational logic feeding the
// stage-1 registers and the combinational logic feeding the stage-2 registers.
// No pipeline registers or handshake logic live here.
// Optional build macro VALU_SATURATE_EN: op 001 saturates to all-ones on carry
// and op 010 saturates to zero on borrow instead of wrapping.
module vector_alu_lane
    import vector_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    // Stage-1 inputs (straight from the transaction)
    input  valu_op_e           op_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    // Stage-1 partial results, to be registered by the top
    output logic [WIDTH+1:0]   wsum_o,
    output logic [WIDTH:0]     sum_o,
    output logic [WIDTH:0]     diff_o,
    // Stage-2 inputs (registered stage-1 values)
    input  valu_op_e           s1_op_i,
    input  logic               s1_mask_i,
    input  logic [WIDTH-1:0]   s1_a_i,
    input  logic [WIDTH+1:0]   s1_wsum_i,
    input  logic [WIDTH:0]     s1_sum_i,
    input  logic [WIDTH:0]     s1_diff_i,
    // Final lane result, to be registered by the top
    output logic [WIDTH-1:0]   result_o,
    output logic               borrow_o
);

    logic [WIDTH+1:0] a_ext;
    logic [WIDTH+1:0] b_ext;
    logic [WIDTH+1:0] quot_full;
    logic             unused_bits;

    assign a_ext = {2'b00, a_i};
    assign b_ext = {2'b00, b_i};

    // Weighted sum is one extra bit wider than 2*max so it never overflows.
    assign wsum_o = (op_i == OP_INT12) ? (a_ext + (b_ext << 1))
                                       : ((a_ext << 1) + b_ext);

    // Bit WIDTH of the difference is the unsigned A<B borrow.
    assign sum_o  = {1'b0, a_i} + {1'b0, b_i};
    assign diff_o = {1'b0, a_i} - {1'b0, b_i};

    // The quotient of a value below 3*2^WIDTH by 3 always fits in WIDTH bits.
    assign quot_full   = s1_wsum_i / (WIDTH+2)'(DIV_CONST);
    assign unused_bits = ^{quot_full[WIDTH+1:WIDTH], s1_sum_i[WIDTH]};

    // Stage-2 result select: reserved ops zero, masked lanes pass A.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        result_o = '0;
        borrow_o = 1'b0;
        if (s1_op_i != OP_RSV6 && s1_op_i != OP_RSV7) begin
            if (!s1_mask_i) begin
                result_o = s1_a_i;
            end else begin
                case (s1_op_i)
                    OP_PASS:  result_o = s1_a_i;
`ifdef VALU_SATURATE_EN
                    OP_ADD:   result_o = s1_sum_i[WIDTH]  ? '1 : s1_sum_i[WIDTH-1:0];
                    OP_SUB:   result_o = s1_diff_i[WIDTH] ? '0 : s1_diff_i[WIDTH-1:0];
`else
                    OP_ADD:   result_o = s1_sum_i[WIDTH-1:0];
                    OP_SUB:   result_o = s1_diff_i[WIDTH-1:0];
`endif
                    OP_CSUB:  result_o = s1_diff_i[WIDTH] ? s1_a_i : s1_diff_i[WIDTH-1:0];
                    OP_INT21,
                    OP_INT12: result_o = quot_full[WIDTH-1:0];
                    default:  result_o = '0;
                endcase
                borrow_o = (s1_op_i == OP_SUB || s1_op_i == OP_CSUB) && s1_diff_i[WIDTH];
            end
        end
    end

endmodule

// File: rtl/vector_alu_pipe.sv
// Two-stage pipelined vector ALU with valid/ready handshakes on both sides.
// LANES independent unsigned WIDTH-bit lanes share one op code per transaction.
// Optional build macro VALU_SATURATE_EN (handled in vector_alu_lane) makes
// add/subtract saturate instead of wrap.
module vector_alu_pipe
    import vector_alu_pkg::*;
#(
    parameter int LANES = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_op,
    input  logic [LANES-1:0]       in_mask,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       out_borrow
);

    valu_op_e               in_op_e;
    logic                   s1_valid_q, s1_valid_d;
    logic                   out_valid_q, out_valid_d;
    logic                   s2_ready;
    logic                   accept;
    logic                   s2_load;

    // Stage-1 registers
    valu_op_e               s1_op_q;
    logic [LANES-1:0]       s1_mask_q;
    logic [WIDTH-1:0]       s1_a_q    [LANES];
    logic [WIDTH+1:0]       s1_wsum_q [LANES];
    logic [WIDTH:0]         s1_sum_q  [LANES];
    logic [WIDTH:0]         s1_diff_q [LANES];

    // Lane combinational outputs
    logic [WIDTH+1:0]       wsum_c    [LANES];
    logic [WIDTH:0]         sum_c     [LANES];
    logic [WIDTH:0]         diff_c    [LANES];
    logic [WIDTH-1:0]       result_c  [LANES];
    logic [LANES-1:0]       borrow_c;

    // Stage-2 (output) registers
    logic [LANES*WIDTH-1:0] out_data_q;
    logic [LANES-1:0]       out_borrow_q;

    assign in_op_e = valu_op_e'(in_op);

    // Stage 2 can take new data unless it holds a result the consumer is refusing;
    // stage 1 can take new data unless it is full and cannot move forward.
    assign s2_ready = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_ready;
    assign accept   = in_valid && in_ready;
    assign s2_load  = s1_valid_q && s2_ready;

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_borrow = out_borrow_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        vector_alu_lane #(.WIDTH(WIDTH)) u_lane (
            .op_i      (in_op_e),
            .a_i       (in_a[i*WIDTH +: WIDTH]),
            .b_i       (in_b[i*WIDTH +: WIDTH]),
            .wsum_o    (wsum_c[i]),
            .sum_o     (sum_c[i]),
            .diff_o    (diff_c[i]),
            .s1_op_i   (s1_op_q),
            .s1_mask_i (s1_mask_q[i]),
            .s1_a_i    (s1_a_q[i]),
            .s1_wsum_i (s1_wsum_q[i]),
            .s1_sum_i  (s1_sum_q[i]),
            .s1_diff_i (s1_diff_q[i]),
            .result_o  (result_c[i]),
            .borrow_o  (borrow_c[i])
        );
    end

    // Next-state of the two stage valid flags.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        out_valid_d = out_valid_q;
        if (in_ready) s1_valid_d  = in_valid;
        if (s2_ready) out_valid_d = s1_valid_q;
    end

    // Valid flags: reset discards everything in flight.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Stage 1: capture op, mask and per-lane partial results on accept.
    // NOTE: payload registers have no reset; the cleared valid flag keeps stale data unobserved.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_op_q   <= in_op_e;
            s1_mask_q <= in_mask;
            for (int i = 0; i < LANES; i++) begin
                s1_a_q[i]    <= in_a[i*WIDTH +: WIDTH];
                s1_wsum_q[i] <= wsum_c[i];
                s1_sum_q[i]  <= sum_c[i];
                s1_diff_q[i] <= diff_c[i];
            end
        end
    end

    // Stage 2: load final lane results; holds stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q   <= '0;
            out_borrow_q <= '0;
        end else if (s2_load) begin
            for (int i = 0; i < LANES; i++) begin
                out_data_q[i*WIDTH +: WIDTH] <= result_c[i];
            end
            out_borrow_q <= borrow_c;
        end
    end

endmodule

// File: doc/vector_alu_pipe.md
Name: vector_alu_pipe

Overview:
- Parametrised, pipelined successor of the per-lane vector ALU in the processor's VectorALU stage.
- Processes LANES independent unsigned lanes of WIDTH bits per transaction.
- Operations: pass, add, subtract, clamp-subtract and two 1/3-weighted interpolations, (2A+B)/3 and (A+2B)/3.
- Two-stage pipeline with valid/ready handshakes on both sides; sits between the vector register read and vector writeback.

Parameters:
- LANES, 4, number of parallel lanes
- WIDTH, 32, bits per lane operand and result

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  transaction offered
- in_ready  out  1  block accepts transaction this cycle
- in_op  in  3  operation code (applies to all lanes)
- in_mask  in  LANES  per-lane enable; 0 = lane passes inputA unchanged
- in_a  in  LANES*WIDTH  operand A, lane i at bits [i*WIDTH +: WIDTH]
- in_b  in  LANES*WIDTH  operand B, same packing
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  LANES*WIDTH  lane results, same packing
- out_borrow  out  LANES  per-lane A<B flag for ops 010/011, else 0

Behaviour:
- Clock/reset: one clock, clk; rst is synchronous and active-high.
- Reset: both stage valid flags cleared; out_valid=0, out_data=0, out_borrow=0. in_ready=1 in the cycle after reset deasserts.
- Reset mid-operation: any in-flight transactions are discarded, with no output for them.
- Handshake:
  - A transfer occurs on a cycle with valid&ready.
  - in_ready = !s1_valid | !s2_valid | out_ready, i.e. the pipeline advances unless both stages are full and the output is stalled.
  - Stage 2 holds while out_valid & !out_ready; out_data must remain stable while stalled.
  - Simultaneous accept and retire in the same cycle is allowed: full throughput, 1 transaction/cycle.
- Latency: a transaction accepted in cycle N appears with out_valid=1 in cycle N+2 when there is no back-pressure.
- Stage 1 (register):
  - per-lane weighted sum S on WIDTH+2 bits: 2A+B for op 100, A+2B for op 101
  - A+B and A-B on WIDTH+1 bits
  - registered op and mask
- Stage 2 (register), divide-by-constant-3 of S. The quotient always fits in WIDTH bits because max = 2^WIDTH-1.
- Op codes:
  - 000 = A
  - 001 = A+B, wraps mod 2^WIDTH
  - 010 = A-B, wraps
  - 011 = clamp-sub: A if A<B, else A-B
  - 100 = (2A+B)/3, truncating
  - 101 = (A+2B)/3, truncating
  - 110, 111 = 0 on every lane, including masked lanes
- Mask: for op != 110/111, a lane with in_mask=0 outputs A and out_borrow=0.
- out_borrow: per-lane unsigned A<B, valid only for ops 010/011.

Optional Feature:
- Macro: VALU_SATURATE_EN.
- Defined:
  - op 001 saturates to 2^WIDTH-1 on carry
  - op 010 saturates to 0 on borrow
  - out_borrow behaves as above
- Undefined: 001 and 010 wrap as specified. No other behaviour changes.

Decomposition:
- Package vector_alu_pkg holds:
  - typedef valu_op_e, 3-bit enum: OP_PASS, OP_ADD, OP_SUB, OP_CSUB, OP_INT21, OP_INT12, OP_RSV6, OP_RSV7
  - localparam DIV_CONST=3
- Sub-module vector_alu_lane:
  - one lane's datapath, stage-1 combinational part plus stage-2 combinational part, parametrised on WIDTH
  - instantiated LANES times with a generate loop
  - valid/ready control lives only in the top module

Test Plan:
- LANES=4, WIDTH=32, op 100, A=9, B=3 all lanes, mask=1111, out_ready=1 -> out_data lanes=7 at cycle N+2, out_valid for exactly one cycle.
- Op 101, A=0, B=0xFFFFFFFF -> 0xAAAAAAAA. Op 100, A=B=0xFFFFFFFF -> 0xFFFFFFFF, no overflow.
- Op 011, lanes A={5,2,7,0}, B={3,4,7,1} -> {2,2,0,0} with out_borrow=0b1010 (lane 0 is the LSB).
- Op 001, A=0xFFFFFFFF, B=2 -> 0x00000001 without the macro, 0xFFFFFFFF with VALU_SATURATE_EN. Op 010, A=1, B=2 -> 0xFFFFFFFF, or 0 with the macro.
- Back-pressure: stream of 5 transactions (op 000, A=1..5), out_ready low for 3 cycles.
  - in_ready drops once both stages are full
  - out_data stays stable while stalled
  - all 5 results arrive in order with none lost or duplicated
- rst asserted with 2 in flight -> next cycle out_valid=0; only transactions accepted after reset appear at the output. Op 110 with mask=0000 -> all lanes 0.
